// File: rtl/bitrev_pingpong.sv
// -----------------------------------------------------------------------------
// bitrev_pingpong
//
// Double-buffered bit-reversal reorder stage. Frames arrive in bit-reversed
// order (e.g. from an FFT butterfly) and leave in natural order. The word that
// arrives at position w is scattered to address rev_K(w) of the write bank.
// The read side gathers that bank in linear order. Two N-word banks (ping/pong)
// let one frame fill while the other drains, so the steady-state throughput is
// one word per cycle.
//
// Parameters
//   K   log2 of the frame length (N = 2**K words), K >= 1
//   DW  data word width in bits
//
// Ports
//   clk_i    in   1   clock, rising edge
//   rst_ni   in   1   asynchronous active-low reset (synchronous release)
//   valid_i  in   1   input word valid
//   data_i   in   DW  input word (arrival position w within the frame)
//   ready_o  out  1   write bank can accept a word
//   valid_o  out  1   output word valid
//   data_o   out  DW  output word, natural order
//   ready_i  in   1   downstream accepts the output word
//   last_i   in   1   input frame terminator      (BITREV_PINGPONG_LAST_EN only)
//   last_o   out  1   last word of output frame   (BITREV_PINGPONG_LAST_EN only)
//   err_o    out  1   sticky short-frame abort    (BITREV_PINGPONG_LAST_EN only)
//
// Configuration macro
//   BITREV_PINGPONG_LAST_EN  adds last_i / last_o / err_o. A last_i seen on a
//   write before the final frame position aborts the frame: the bank returns
//   to EMPTY, the write counter restarts and err_o is set until reset.
//
// Memory contents are never reset; only control state is.
// -----------------------------------------------------------------------------
module bitrev_pingpong #(
  parameter int K  = 10,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i
`ifdef BITREV_PINGPONG_LAST_EN
  ,
  input  logic          last_i,
  output logic          last_o,
  output logic          err_o
`endif
);

  localparam int N = 1 << K;
  localparam logic [K-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_state_e;

  // Reverse the K address bits only.
  function automatic logic [K-1:0] rev_k(input logic [K-1:0] a);
    logic [K-1:0] r;
    for (int i = 0; i < K; i++) begin
      r[i] = a[K-1-i];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bank_state_e  bank_q [2];
  bank_state_e  bank_d [2];
  logic [K-1:0] wr_cnt_q,  wr_cnt_d;
  logic [K-1:0] rd_cnt_q,  rd_cnt_d;
  logic         wr_bank_q, wr_bank_d;
  logic         rd_bank_q, rd_bank_d;
`ifdef BITREV_PINGPONG_LAST_EN
  logic         err_q,     err_d;
`endif

  // Both banks flattened into one array; the bank select is the address MSB.
  logic [DW-1:0] mem_q [2*N];

  logic wr_fire;
  logic rd_fire;
  logic wr_last;
  logic rd_last;
  logic wr_abort;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // ready_o is held low while reset is asserted even though the bank state
  // already reads EMPTY; neither handshake output looks at the opposite
  // side's valid/ready, so there is no combinational path through the block.
  assign ready_o = rst_ni &&
                   ((bank_q[wr_bank_q] == ST_EMPTY) ||
                    (bank_q[wr_bank_q] == ST_FILLING));
  assign valid_o = (bank_q[rd_bank_q] == ST_FULL) ||
                   (bank_q[rd_bank_q] == ST_DRAINING);

  assign wr_fire = valid_i && ready_o;
  assign rd_fire = valid_o && ready_i;
  assign wr_last = (wr_cnt_q == CNT_MAX);
  assign rd_last = (rd_cnt_q == CNT_MAX);

`ifdef BITREV_PINGPONG_LAST_EN
  assign wr_abort = wr_fire && last_i && !wr_last;
  assign last_o   = valid_o && rd_last;
  assign err_o    = err_q;
`else
  assign wr_abort = 1'b0;
`endif

  // Read data is gated so data_o is zero whenever nothing is offered; this
  // also hides the unreset memory after power-up.
  assign data_o = valid_o ? mem_q[{rd_bank_q, rd_cnt_q}] : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // The write bank is never FULL/DRAINING and the read bank always is, so the
  // two sides never update the same bank entry in one cycle. A last write into
  // one bank and a last read from the other therefore both take effect.
  always_comb begin
    bank_d    = bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
`ifdef BITREV_PINGPONG_LAST_EN
    err_d     = err_q;
`endif

    if (wr_fire) begin
      if (wr_abort) begin
        bank_d[wr_bank_q] = ST_EMPTY;
        wr_cnt_d          = '0;
`ifdef BITREV_PINGPONG_LAST_EN
        err_d             = 1'b1;
`endif
      end else if (wr_last) begin
        bank_d[wr_bank_q] = ST_FULL;
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = ST_FILLING;
        wr_cnt_d          = wr_cnt_q + 1'b1;
      end
    end

    if (rd_fire) begin
      if (rd_last) begin
        bank_d[rd_bank_q] = ST_EMPTY;
        rd_cnt_d          = '0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        bank_d[rd_bank_q] = ST_DRAINING;
        rd_cnt_d          = rd_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q[0] <= ST_EMPTY;
      bank_q[1] <= ST_EMPTY;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
`ifdef BITREV_PINGPONG_LAST_EN
      err_q     <= 1'b0;
`endif
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
`ifdef BITREV_PINGPONG_LAST_EN
      err_q     <= err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Frame memory (scatter on write, linear gather on read)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[{wr_bank_q, rev_k(wr_cnt_q)}] <= data_i;
    end
  end

`ifndef SYNTHESIS
  // An offered word must not change until it is taken.
  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
`endif

endmodule

// File: tb/tb_bitrev_pingpong.sv
module tb_bitrev_pingpong;

  localparam int K  = 10;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          valid_i, ready_i, ready_o, valid_o;
  logic [DW-1:0] data_i, data_o;

  logic          s3_vi, s3_ri, s3_ready, s3_vo;
  logic [7:0]    s3_di, s3_do;
  logic          s1_vi, s1_ri, s1_ready, s1_vo;
  logic [7:0]    s1_di, s1_do;

`ifdef BITREV_PINGPONG_LAST_EN
  logic last_i, last_o, err_o;
  logic s3_last_i, s3_last_o, s3_err_o;
  logic s1_last_i, s1_last_o, s1_err_o;
`endif

  int n_cmp;
  int n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bitrev_pingpong #(.K(K), .DW(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i)
`ifdef BITREV_PINGPONG_LAST_EN
    , .last_i(last_i), .last_o(last_o), .err_o(err_o)
`endif
  );

  bitrev_pingpong #(.K(3), .DW(8)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(s3_vi), .data_i(s3_di),
    .ready_o(s3_ready), .valid_o(s3_vo), .data_o(s3_do), .ready_i(s3_ri)
`ifdef BITREV_PINGPONG_LAST_EN
    , .last_i(s3_last_i), .last_o(s3_last_o), .err_o(s3_err_o)
`endif
  );

  bitrev_pingpong #(.K(1), .DW(8)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(s1_vi), .data_i(s1_di),
    .ready_o(s1_ready), .valid_o(s1_vo), .data_o(s1_do), .ready_i(s1_ri)
`ifdef BITREV_PINGPONG_LAST_EN
    , .last_i(s1_last_i), .last_o(s1_last_o), .err_o(s1_err_o)
`endif
  );

  // Bit reversal of the low nb bits of v, built by shifting bits out LSB-first.
  function automatic int rev_bits(input int v, input int nb);
    int r;
    r = 0;
    for (int i = 0; i < nb; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // k-th natural-order output when input word w of frame f carried base+f*1024+w.
  function automatic logic [31:0] exp_word(input logic [31:0] base, input int k);
    return base + 32'((k / 1024) * 1024 + rev_bits(k % 1024, 10));
  endfunction

  // One clock cycle on the K=10 instance: drive at edge+1, sample at edge+5.
  task automatic cycle(input logic vi, input logic [31:0] di, input logic ri,
                       output logic ai, output logic ao, output logic vo,
                       output logic [31:0] dout);
    valid_i = vi;
    data_i  = di;
    ready_i = ri;
    #4;
    ai   = vi && ready_o;
    ao   = valid_o && ri;
    vo   = valid_o;
    dout = data_o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    n_cmp++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", data_o); end
    n_cmp++; if (s3_vo !== 1'b0 || s1_vo !== 1'b0) begin n_fail++; $display("FAIL rst_small_valid: got %b%b want 00", s3_vo, s1_vo); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b want 1", ready_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rel_valid: got %b want 0", valid_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame(input string tag);
    logic ai, ao, vo;
    logic [31:0] d;
    logic [31:0] cap [4];
    for (int w = 0; w < 1024; w++) begin
      cycle(1'b1, 32'(w), 1'b1, ai, ao, vo, d);
      n_cmp++; if (ai !== 1'b1 || vo !== 1'b0) begin n_fail++; $display("FAIL %s_fill w=%0d: accept=%b valid=%b want 1/0", tag, w, ai, vo); end
    end
    for (int j = 0; j < 1024; j++) begin
      cycle(1'b0, 32'h0, 1'b1, ai, ao, vo, d);
      n_cmp++; if (vo !== 1'b1 || d !== 32'(rev_bits(j, 10))) begin n_fail++; $display("FAIL %s_out j=%0d: valid=%b data=%0d want 1/%0d", tag, j, vo, d, rev_bits(j, 10)); end
      if (j == 0) cap[0] = d;
      if (j == 1) cap[1] = d;
      if (j == 2) cap[2] = d;
      if (j == 1023) cap[3] = d;
    end
    n_cmp++; if (cap[0] !== 32'd0)    begin n_fail++; $display("FAIL %s_out0: got %0d want 0", tag, cap[0]); end
    n_cmp++; if (cap[1] !== 32'd512)  begin n_fail++; $display("FAIL %s_out1: got %0d want 512", tag, cap[1]); end
    n_cmp++; if (cap[2] !== 32'd256)  begin n_fail++; $display("FAIL %s_out2: got %0d want 256", tag, cap[2]); end
    n_cmp++; if (cap[3] !== 32'd1023) begin n_fail++; $display("FAIL %s_out1023: got %0d want 1023", tag, cap[3]); end
    cycle(1'b0, 32'h0, 1'b1, ai, ao, vo, d);
    n_cmp++; if (vo !== 1'b0) begin n_fail++; $display("FAIL %s_drained: valid=%b want 0", tag, vo); end
  endtask

  task automatic test_back_to_back();
    logic ai, ao, vo;
    logic [31:0] d;
    int in_cnt, k;
    in_cnt = 0;
    k = 0;
    for (int c = 0; c < 6000 && k < 4096; c++) begin
      cycle(in_cnt < 4096, 32'(in_cnt), 1'b1, ai, ao, vo, d);
      if (in_cnt < 4096) begin
        n_cmp++; if (ai !== 1'b1) begin n_fail++; $display("FAIL b2b_ready in=%0d: got %b want 1", in_cnt, ai); end
      end
      if (k > 0) begin
        n_cmp++; if (vo !== 1'b1) begin n_fail++; $display("FAIL b2b_rate k=%0d: valid=%b want 1", k, vo); end
      end
      if (ai) in_cnt++;
      if (ao) begin
        n_cmp++; if (d !== exp_word(32'h0, k)) begin n_fail++; $display("FAIL b2b_data k=%0d: got %h want %h", k, d, exp_word(32'h0, k)); end
        k++;
      end
    end
    n_cmp++; if (k !== 4096) begin n_fail++; $display("FAIL b2b_count: got %0d words want 4096", k); end
  endtask

  task automatic test_backpressure();
    logic ai, ao, vo;
    logic [31:0] d;
    logic [31:0] base;
    int in_cnt, k;
    logic chk;
    base = 32'h0003_0000;
    in_cnt = 0;
    k = 0;
    ai = 1'b0;
    vo = 1'b0;
    for (int c = 0; c < 2060; c++) begin
      cycle(1'b1, base + 32'(in_cnt), 1'b0, ai, ao, vo, d);
      if (ai) in_cnt++;
    end
    n_cmp++; if (in_cnt !== 2048) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2048", in_cnt); end
    n_cmp++; if (ai !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", ai); end
    n_cmp++; if (vo !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", vo); end
    chk = 1'b0;
    for (int c = 0; c < 5000 && k < 3072; c++) begin
      cycle(in_cnt < 3072, base + 32'(in_cnt), 1'b1, ai, ao, vo, d);
      if (chk) begin
        n_cmp++; if (ai !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_free: got %b want 1", ai); end
        chk = 1'b0;
      end
      if (ao && k == 1023) begin
        n_cmp++; if (ai !== 1'b0) begin n_fail++; $display("FAIL bp_ready_before_free: got %b want 0", ai); end
        chk = 1'b1;
      end
      if (ai) in_cnt++;
      if (ao) begin
        n_cmp++; if (d !== exp_word(base, k)) begin n_fail++; $display("FAIL bp_data k=%0d: got %h want %h", k, d, exp_word(base, k)); end
        k++;
      end
    end
    n_cmp++; if (k !== 3072) begin n_fail++; $display("FAIL bp_count: got %0d words want 3072", k); end
  endtask

  task automatic test_random_gaps();
    logic ai, ao, vo, vi, ri, pvo, pri;
    logic [31:0] d, pd;
    logic [31:0] base;
    int in_cnt, k;
    base = 32'h0004_0000;
    in_cnt = 0;
    k = 0;
    pvo = 1'b0;
    pri = 1'b0;
    pd = '0;
    for (int c = 0; c < 40000 && k < 8192; c++) begin
      vi = (in_cnt < 8192) && ($urandom_range(0, 1) == 1);
      ri = ($urandom_range(0, 1) == 1);
      cycle(vi, base + 32'(in_cnt), ri, ai, ao, vo, d);
      if (pvo && !pri) begin
        n_cmp++; if (vo !== 1'b1 || d !== pd) begin n_fail++; $display("FAIL rnd_stable k=%0d: valid=%b data=%h want 1/%h", k, vo, d, pd); end
      end
      if (ai) in_cnt++;
      if (ao) begin
        n_cmp++; if (d !== exp_word(base, k)) begin n_fail++; $display("FAIL rnd_data k=%0d: got %h want %h", k, d, exp_word(base, k)); end
        k++;
      end
      pvo = vo;
      pri = ri;
      pd = d;
    end
    n_cmp++; if (k !== 8192 || in_cnt !== 8192) begin n_fail++; $display("FAIL rnd_count: in=%0d out=%0d want 8192/8192", in_cnt, k); end
  endtask

  task automatic test_reset_midop();
    logic ai, ao, vo;
    logic [31:0] d;
    logic [31:0] base;
    int in_cnt, k;
    base = 32'h0005_0000;
    in_cnt = 0;
    k = 0;
    for (int c = 0; c < 1100 && in_cnt < 1024; c++) begin
      cycle(1'b1, base + 32'(in_cnt), 1'b0, ai, ao, vo, d);
      if (ai) in_cnt++;
    end
    for (int c = 0; c < 400 && in_cnt < 1324; c++) begin
      cycle(1'b1, base + 32'(in_cnt), 1'b1, ai, ao, vo, d);
      if (ai) in_cnt++;
      if (ao) begin
        n_cmp++; if (d !== exp_word(base, k)) begin n_fail++; $display("FAIL mid_data k=%0d: got %h want %h", k, d, exp_word(base, k)); end
        k++;
      end
    end
    n_cmp++; if (in_cnt !== 1324 || k !== 300) begin n_fail++; $display("FAIL mid_progress: in=%0d out=%0d want 1324/300", in_cnt, k); end
    rst_n = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst: valid=%b ready=%b want 0/0", valid_o, ready_o); end
    n_cmp++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0", data_o); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_release: valid=%b ready=%b want 0/1", valid_o, ready_o); end
    test_single_frame("mid_fresh");
  endtask

  task automatic test_small_k();
    int exp3 [8];
    int exp1 [4];
    int in_cnt, k;
    logic ai, ao;
    exp3 = '{10, 14, 12, 16, 11, 15, 13, 17};
    exp1 = '{20, 21, 30, 31};
    for (int w = 0; w < 8; w++) begin
      s3_vi = 1'b1; s3_di = 8'(10 + w); s3_ri = 1'b0;
      #4;
      n_cmp++; if (s3_ready !== 1'b1) begin n_fail++; $display("FAIL k3_ready w=%0d: got %b want 1", w, s3_ready); end
      @(posedge clk); #1;
    end
    s3_vi = 1'b0; s3_ri = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #4;
      n_cmp++; if (s3_vo !== 1'b1 || s3_do !== 8'(exp3[j])) begin n_fail++; $display("FAIL k3_out j=%0d: valid=%b data=%0d want 1/%0d", j, s3_vo, s3_do, exp3[j]); end
`ifdef BITREV_PINGPONG_LAST_EN
      n_cmp++; if (s3_last_o !== (j == 7)) begin n_fail++; $display("FAIL k3_last j=%0d: got %b want %b", j, s3_last_o, (j == 7)); end
`endif
      @(posedge clk); #1;
    end
    #4;
    n_cmp++; if (s3_vo !== 1'b0) begin n_fail++; $display("FAIL k3_drained: got %b want 0", s3_vo); end
    @(posedge clk); #1;
    s3_ri = 1'b0;

    in_cnt = 0;
    k = 0;
    s1_ri = 1'b1;
    for (int c = 0; c < 10; c++) begin
      s1_vi = (in_cnt < 4);
      s1_di = (in_cnt < 2) ? 8'(20 + in_cnt) : 8'(28 + in_cnt);
      #4;
      ai = s1_vi && s1_ready;
      ao = s1_vo && s1_ri;
      if (ao) begin
        n_cmp++; if (k >= 4 || s1_do !== 8'(exp1[k % 4])) begin n_fail++; $display("FAIL k1_out k=%0d: got %0d want %0d", k, s1_do, exp1[k % 4]); end
        k++;
      end
      @(posedge clk); #1;
      if (ai) in_cnt++;
    end
    s1_vi = 1'b0;
    n_cmp++; if (k !== 4 || in_cnt !== 4) begin n_fail++; $display("FAIL k1_count: in=%0d out=%0d want 4/4", in_cnt, k); end
  endtask

`ifdef BITREV_PINGPONG_LAST_EN
  task automatic test_last();
    int exp3 [8];
    exp3 = '{40, 44, 42, 46, 41, 45, 43, 47};
    #4;
    n_cmp++; if (s3_err_o !== 1'b0) begin n_fail++; $display("FAIL last_err_init: got %b want 0", s3_err_o); end
    @(posedge clk); #1;
    for (int w = 0; w < 6; w++) begin
      s3_vi = 1'b1; s3_di = 8'(50 + w); s3_last_i = (w == 5); s3_ri = 1'b1;
      @(posedge clk); #1;
    end
    s3_vi = 1'b0; s3_last_i = 1'b0;
    #4;
    n_cmp++; if (s3_err_o !== 1'b1) begin n_fail++; $display("FAIL last_err_set: got %b want 1", s3_err_o); end
    n_cmp++; if (s3_vo !== 1'b0 || s3_ready !== 1'b1) begin n_fail++; $display("FAIL last_abort: valid=%b ready=%b want 0/1", s3_vo, s3_ready); end
    @(posedge clk); #1;
    for (int w = 0; w < 8; w++) begin
      s3_vi = 1'b1; s3_di = 8'(40 + w); s3_last_i = (w == 7);
      #4;
      n_cmp++; if (s3_vo !== 1'b0) begin n_fail++; $display("FAIL last_no_out w=%0d: valid=%b want 0", w, s3_vo); end
      @(posedge clk); #1;
    end
    s3_vi = 1'b0; s3_last_i = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #4;
      n_cmp++; if (s3_vo !== 1'b1 || s3_do !== 8'(exp3[j]) || s3_last_o !== (j == 7)) begin n_fail++; $display("FAIL last_frame j=%0d: valid=%b data=%0d last=%b want 1/%0d/%b", j, s3_vo, s3_do, s3_last_o, exp3[j], (j == 7)); end
      @(posedge clk); #1;
    end
    #4;
    n_cmp++; if (s3_err_o !== 1'b1 || s3_vo !== 1'b0) begin n_fail++; $display("FAIL last_end: err=%b valid=%b want 1/0", s3_err_o, s3_vo); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    s3_vi = 1'b0; s3_ri = 1'b0; s3_di = '0;
    s1_vi = 1'b0; s1_ri = 1'b0; s1_di = '0;
`ifdef BITREV_PINGPONG_LAST_EN
    last_i = 1'b0; s3_last_i = 1'b0; s1_last_i = 1'b0;
`endif
    test_reset();
    test_single_frame("single");
    test_back_to_back();
    test_backpressure();
    test_random_gaps();
    test_reset_midop();
    test_small_k();
`ifdef BITREV_PINGPONG_LAST_EN
    test_last();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
